correlator_sequencer: RTL and testbench
=======================================

# correlator_sequencer

Sequencing controller and sample buffer for the sequential correlator MAC. It loads a block of N sample pairs (a, b) through a valid/ready input stream. It then drives a single clear/enable multiply-accumulate datapath to compute the lagged cross-correlation R[k] = Σ a[i]·b[i+k] for k = 0..LAGS-1, and emits one result per lag on a valid/ready output stream. It sits between the sample source and the downstream peak-detect logic.

## Interface
- N, default 16: samples per block; N ≥ 2.
- LAGS, default 8: number of lags computed; 1 ≤ LAGS ≤ N.
- DATA_W, default 32: signed sample width.
- ACC_W, default 64: signed accumulator and result width; ACC_W ≥ 2·DATA_W.
- clk  in  1: clock; all state changes on the rising edge.
- rst  in  1: reset, asynchronous and active-low.
- in_valid  in  1: a_in/b_in hold a valid pair.
- in_ready  out  1: the block accepts a pair this cycle.
- a_in  in  DATA_W: signed sample a.
- b_in  in  DATA_W: signed sample b.
- out_valid  out  1: out_data/out_lag hold a result.
- out_ready  in  1: downstream accepts the result.
- out_data  out  ACC_W: signed R[k].
- out_lag  out  $clog2(LAGS)+1: lag index k.
- busy  out  1: state ≠ LOAD.

## Operation
- States: LOAD, RUN, PRESENT.
- LOAD
  - in_ready = 1 (gated to 0 while rst is low).
  - Each in_valid&&in_ready beat writes a_buf[wr_idx], b_buf[wr_idx] and increments wr_idx.
  - The beat with wr_idx = N-1 moves to RUN with k = 0, i = 0, wr_idx = 0.
- RUN
  - Each cycle the MAC receives a_buf[i]·b_buf[i+k] with en = 1, clr = (i == 0).
  - Accumulator update: acc <= (clr ? 0 : acc) + product.
  - i increments each cycle. On the cycle with i = N-1-k, move to PRESENT and reset i to 0.
- PRESENT
  - out_valid = 1, out_data = acc, out_lag = k.
  - On out_valid&&out_ready: if k = LAGS-1, move to LOAD; otherwise k+1 and move to RUN.
- Arithmetic
  - Product is a full 2·DATA_W signed product, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W. No saturation and no overflow flag.
- Buffers are register arrays read combinationally by i and i+k. Indices never exceed N-1 by construction.
- Buffer contents persist across blocks. Every entry is overwritten before it is read.

## Timing
- Reset values: in_ready 0 while rst is low, 1 after release (state LOAD). out_valid 0, out_data 0, out_lag 0, busy 0. Counters are 0. Buffers are not reset.
- Reset mid-operation (any state) aborts the block immediately. Pending results are discarded and the first post-reset beat is sample 0.
- Input accepts one pair per cycle at full rate. in_valid low inserts gaps with no effect.
- Lag k occupies N-k RUN cycles. out_valid rises on the cycle after the last RUN cycle.
- Minimum cycles from the last input beat to the final result handshake: Σ(N-k) + LAGS for k = 0..LAGS-1.
- out_valid, out_data and out_lag stay stable while out_valid && !out_ready.
- out_valid never drops without a handshake except on reset.
- in_ready = 0 in RUN and PRESENT. No input is accepted until the last lag is taken.
- On the handshake of the last lag, LOAD is entered on the next edge. The earliest next input beat is the cycle after that handshake.

## Structure
- Shared package corr_pkg holds:
  - the state enum corr_state_t {LOAD, RUN, PRESENT};
  - a localparam-friendly width function for index/lag widths.
- Sub-module corr_mac holds the clear/enable signed MAC register. Its ports are clk, rst, en, clr, a, b and acc; it is parameterised by DATA_W and ACC_W.
- The controller contains the FSM, counters (wr_idx, i, k) and buffers.

## Test plan
All scenarios use N = 4, LAGS = 3, DATA_W = 32, ACC_W = 64 unless noted.
- a = {1,2,3,4}, b = {1,1,1,1} → results (lag, data) = (0,10), (1,6), (2,3), with out_ready held high.
- a = b = {1,2,3,4} → (0,30), (1,20), (2,11). Lag 0 is presented 5 cycles after the last input beat.
- a = {-1,2,-3,4}, b = {1,1,1,1} → (0,2), (1,-2), (2,1). Confirms signed arithmetic.
- a = b = {-2^31 ×4} → lag 0 = 2^64 mod 2^64 = 0. Lag 1 = 3·2^62 as a signed 64-bit value = -2^62. Confirms wrap.
- Hold out_ready = 0 for 5 cycles on lag 1 → out_valid stays 1 with data and lag stable, in_ready stays 0, and the result is released on the first out_ready = 1.
- Assert rst during RUN of lag 1 → all outputs take reset values asynchronously. A fresh block {1,2,3,4}/{1,1,1,1} then yields 10, 6, 3 with no stale result.

Source files
------------

// File: rtl/corr_pkg.sv
// corr_pkg: definitions shared by the correlator sequencer and its MAC.
//   corr_state_t : controller states (LOAD, RUN, PRESENT)
//   idx_w()      : width of an index counter that must address n entries
package corr_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    PRESENT = 2'd2
  } corr_state_t;

  // Bits needed to hold the values 0..n-1. Never returns less than 1 so a
  // counter declared with it is always legal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/corr_mac.sv
// corr_mac: signed clear/enable multiply-accumulate register.
//   clk, rst : clock and asynchronous active-low reset (acc -> 0)
//   en       : update acc this cycle
//   clr      : when en, start from zero instead of the held acc
//   a, b     : signed DATA_W operands
//   acc      : signed ACC_W accumulator, wraps modulo 2^ACC_W
module corr_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  // Widen before multiplying so the full signed product is kept.
  assign a_x      = (2*DATA_W)'(a);
  assign b_x      = (2*DATA_W)'(b);
  assign prod     = a_x * b_x;
  assign prod_ext = ACC_W'(prod);

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? ACC_W'(0) : acc) + prod_ext;
    end
  end

endmodule

// File: rtl/correlator_sequencer.sv
// correlator_sequencer: buffers a block of N (a, b) sample pairs, then
// sequences a single MAC to produce R[k] = sum a[i]*b[i+k], k = 0..LAGS-1,
// presenting each lag on a valid/ready output stream.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid/in_ready   : input pair handshake (a_in, b_in)
//   out_valid/out_ready : result handshake (out_data = R[k], out_lag = k)
//   busy                : high whenever the block is not accepting samples
module correlator_sequencer
  import corr_pkg::*;
#(
  parameter int N      = 16,
  parameter int LAGS   = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  localparam int LAG_W = $clog2(LAGS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [LAG_W-1:0]         out_lag,
  output logic                     busy
);

  localparam int IDX_W = idx_w(N);

  corr_state_t state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] i;
  logic [LAG_W-1:0] k;

  logic signed [DATA_W-1:0] a_buf [N];
  logic signed [DATA_W-1:0] b_buf [N];

  logic [IDX_W-1:0] k_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] last_i;
  logic             in_fire;
  logic             run_en;

  // k never exceeds LAGS-1 <= N-1, so narrowing to index width is lossless.
  assign k_idx   = IDX_W'(k);
  assign rd_idx  = i + k_idx;
  assign last_i  = IDX_W'(N - 1) - k_idx;

  // rst gates in_ready so nothing is offered while the block is held.
  assign in_ready  = rst && (state == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign run_en    = (state == RUN);
  assign out_valid = (state == PRESENT);
  assign out_lag   = k;
  assign busy      = (state != LOAD);

  // NOTE: the sample buffers are deliberately left out of reset; every
  // entry is rewritten by the load phase before RUN reads it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_buf[wr_idx] <= a_in;
      b_buf[wr_idx] <= b_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= LOAD;
      wr_idx <= '0;
      i      <= '0;
      k      <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_idx == IDX_W'(N - 1)) begin
              state  <= RUN;
              wr_idx <= '0;
              i      <= '0;
              k      <= '0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        RUN: begin
          // Lag k sums over i = 0..N-1-k; the MAC captures the last term
          // on the same edge that enters PRESENT.
          if (i == last_i) begin
            state <= PRESENT;
            i     <= '0;
          end else begin
            i <= i + 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            if (k == LAG_W'(LAGS - 1)) begin
              state <= LOAD;
            end else begin
              k     <= k + 1'b1;
              state <= RUN;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  corr_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .clr (i == '0),
    .a   (a_buf[i]),
    .b   (b_buf[rd_idx]),
    .acc (out_data)
  );

endmodule

// File: tb/tb_correlator_sequencer.sv
// Self-checking bench for correlator_sequencer (N=4, LAGS=3, 32/64 bits):
// directed vectors with fixed expectations, backpressure and reset corner
// cases, then random blocks compared against a direct summation model.
module tb_correlator_sequencer;

  localparam int N    = 4;
  localparam int LAGS = 3;
  localparam int DW   = 32;
  localparam int AW   = 64;
  localparam int LW   = $clog2(LAGS) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a_in;
  logic signed [DW-1:0] b_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;
  logic [LW-1:0]        out_lag;
  logic                 busy;

  correlator_sequencer #(
    .N      (N),
    .LAGS   (LAGS),
    .DATA_W (DW),
    .ACC_W  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lag   (out_lag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][DW-1:0]    a;
    logic [N-1:0][DW-1:0]    b;
    logic [LAGS-1:0][AW-1:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  function automatic vec_t mk(input longint a0, a1, a2, a3,
                              input longint b0, b1, b2, b3,
                              input longint e0, e1, e2);
    vec_t v;
    v.a[0] = DW'(a0); v.a[1] = DW'(a1); v.a[2] = DW'(a2); v.a[3] = DW'(a3);
    v.b[0] = DW'(b0); v.b[1] = DW'(b1); v.b[2] = DW'(b2); v.b[3] = DW'(b3);
    v.exp[0] = AW'(e0); v.exp[1] = AW'(e1); v.exp[2] = AW'(e2);
    return v;
  endfunction

  // Reference: R[k] = sum over valid i of a[i]*b[i+k], 64-bit wrapping.
  function automatic logic [AW-1:0] ref_r(input logic [N-1:0][DW-1:0] a,
                                          input logic [N-1:0][DW-1:0] b,
                                          input int k);
    longint s = 0;
    for (int n = 0; n + k < N; n++)
      s += longint'($signed(a[n])) * longint'($signed(b[n + k]));
    return AW'(s);
  endfunction

  // All tasks enter and leave just after a falling edge.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) timeout("push");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int lag, input logic [AW-1:0] exp, input int hold);
    int t = 0;
    logic [AW-1:0] d0;
    logic [LW-1:0] l0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (!out_valid) begin timeout("collect"); return; end
    check($sformatf("lag%0d index", lag), AW'(out_lag), AW'(lag));
    check($sformatf("lag%0d data", lag), out_data, exp);
    check("in_ready low while presenting", AW'(in_ready), 0);
    check("busy while presenting", AW'(busy), 1);
    d0 = out_data; l0 = out_lag;
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold valid", AW'(out_valid), 1);
      check("hold data", out_data, d0);
      check("hold lag", AW'(out_lag), AW'(l0));
      check("hold in_ready", AW'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("valid drops after handshake", AW'(out_valid), 0);
  endtask

  task automatic run_block(input vec_t v, input int gap_max, input int hold_max);
    int lat = 0;
    for (int s = 0; s < N; s++)
      push(v.a[s], v.b[s], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    // Last beat accepted one edge ago; lag 0 follows N RUN cycles later.
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    check("lag0 latency", AW'(lat), AW'(N));
    for (int k = 0; k < LAGS; k++)
      collect(k, v.exp[k], (hold_max > 0) ? $urandom_range(0, hold_max) : 0);
    check("in_ready after last lag", AW'(in_ready), 1);
  endtask

  vec_t vecs[4];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1, 2, 3, 4, 1, 1, 1, 1, 10, 6, 3);
    vecs[1] = mk(1, 2, 3, 4, 1, 2, 3, 4, 30, 20, 11);
    vecs[2] = mk(-1, 2, -3, 4, 1, 1, 1, 1, 2, -2, 1);
    vecs[3] = mk(-(64'sd1 <<< 31), -(64'sd1 <<< 31), -(64'sd1 <<< 31), -(64'sd1 <<< 31),
                 -(64'sd1 <<< 31), -(64'sd1 <<< 31), -(64'sd1 <<< 31), -(64'sd1 <<< 31),
                 0, -(64'sd1 <<< 62), -(64'sd1 <<< 63));

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", AW'(in_ready), 0);
    check("reset out_valid", AW'(out_valid), 0);
    check("reset out_data", out_data, 0);
    check("reset out_lag", AW'(out_lag), 0);
    check("reset busy", AW'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready after release", AW'(in_ready), 1);

    for (int v = 0; v < 4; v++) run_block(vecs[v], 0, 0);

    // Backpressure on lag 1 for five cycles.
    for (int s = 0; s < N; s++) push(vecs[1].a[s], vecs[1].b[s], 0);
    collect(0, vecs[1].exp[0], 0);
    collect(1, vecs[1].exp[1], 5);
    collect(2, vecs[1].exp[2], 0);

    // Reset during RUN of lag 1, then a clean block.
    for (int s = 0; s < N; s++) push(vecs[1].a[s], vecs[1].b[s], 0);
    collect(0, vecs[1].exp[0], 0);
    @(negedge clk);
    check("busy before mid reset", AW'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid reset in_ready", AW'(in_ready), 0);
    check("mid reset out_valid", AW'(out_valid), 0);
    check("mid reset out_data", out_data, 0);
    check("mid reset out_lag", AW'(out_lag), 0);
    check("mid reset busy", AW'(busy), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("in_ready after mid reset", AW'(in_ready), 1);
    run_block(vecs[0], 0, 0);

    // Random blocks with input gaps and output stalls.
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < N; s++) begin
        case ($urandom_range(0, 3))
          0:       begin rv.a[s] = 32'h8000_0000; rv.b[s] = $urandom(); end
          1:       begin rv.a[s] = $urandom_range(0, 15); rv.b[s] = -$urandom_range(0, 15); end
          default: begin rv.a[s] = $urandom(); rv.b[s] = $urandom(); end
        endcase
      end
      for (int k = 0; k < LAGS; k++) rv.exp[k] = ref_r(rv.a, rv.b, k);
      run_block(rv, 2, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
